subsystem_eq1_inv: RTL
======================

SUBSYSTEM_EQ1_INV -- requirements
Module: subsystem_eq1_inv

Interface
REQ-001 The block SHALL take parameter N, default `FXP_N, the fixed-point word width.
REQ-002 The block SHALL take parameter FRAC, default `FXP_FRAC, the fraction bits; all data ports SHALL be signed Q(N,FRAC).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand set valid.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 O_in  input  N  equation output value O.
REQ-008 I2_in  input  N  coefficient I2.
REQ-009 I3_in  input  N  coefficient I3.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 I1_out  output  N  recovered I1.
REQ-013 sat  output  1  I1_out was saturated, including the divide-by-zero case.
REQ-014 div0  output  1  denominator was zero.

Function
REQ-015 The block SHALL solve O = I3*I3*(1-I1) + I2*I1 for I1, that is I1 = (O - t0)/(I2 - t0).
REQ-016 t0 SHALL equal (I3*I3) >>> FRAC, truncated to the low N bits of the shifted product, matching the forward path.
REQ-017 num = O - t0 and den = I2 - t0 SHALL each be computed at N+1 bits with no wrap.
REQ-018 The quotient SHALL be (num <<< FRAC)/den.
 - Computed on magnitudes using an unsigned restoring divider.
 - Dividend width W = N+1+FRAC.
 - One quotient bit per cycle, W iterations.
REQ-019 The sign SHALL be num_sign XOR den_sign, and the result SHALL truncate toward zero.
REQ-020 A signed result outside [-2^(N-1), 2^(N-1)-1] SHALL saturate to the nearest limit with sat=1.
REQ-021 If den==0:
 - I1_out = 2^(N-1)-1 when num>=0, else -2^(N-1).
 - div0=1, sat=1.
REQ-022 The FSM SHALL have states IDLE, PREP, DIV, POST and DONE:
 - IDLE->PREP on in_valid&in_ready.
 - PREP (1 cycle): compute t0, num, den and magnitudes; register signs and the div0 flag.
 - PREP->DIV.
 - DIV lasts W cycles, driven by an iteration counter.
 - DIV->POST when the counter reaches W-1.
 - POST (1 cycle): apply sign, saturation and div0 override, then register the outputs.
 - POST->DONE.
 - DONE->IDLE on out_ready.
REQ-023 in_ready SHALL be 1 exactly when the state is IDLE, and operands SHALL be sampled only on the accepting edge.
REQ-024 Latency SHALL be fixed: acceptance at edge k gives out_valid=1 after edge k+W+2, including in the div0 case.
REQ-025 I1_out, sat and div0 SHALL be stable while out_valid=1 and SHALL change only in POST.
REQ-026 out_valid SHALL stay 1 in DONE until out_ready=1, and SHALL drop on the following edge.
REQ-027 There SHALL be no same-cycle result-release-plus-accept: a new acceptance is possible no earlier than one cycle after DONE->IDLE.
REQ-028 Peak throughput SHALL be one result per W+4 cycles.
REQ-029 out_ready asserted while out_valid=0 SHALL be ignored.
REQ-030 Input changes while not in IDLE SHALL have no effect.

Reset
REQ-031 While rst=1 at a clock edge:
 - state -> IDLE, counter -> 0.
 - out_valid=0, I1_out=0, sat=0, div0=0.
 - in_ready=1 from the cycle after the reset edge.
REQ-032 Reset in any state, including mid-DIV, SHALL abandon the operation with no out_valid pulse, and the next acceptance SHALL compute from fresh operands only.
REQ-033 rst SHALL take priority over in_valid and out_ready in the same cycle.

Verification (N=16, FRAC=8, W=25, latency 27)
REQ-034 Nominal case:
 - Stimulus: O=0x0180, I2=0x0200, I3=0x0100 accepted at edge k.
 - Response: I1_out=0x0080, sat=0, div0=0, out_valid after edge k+27.
REQ-035 Negative denominator case:
 - Stimulus: O=0x00C0, I2=0x0000, I3=0x0100.
 - Response: I1_out=0x0040, sat=0.
REQ-036 Truncation toward zero:
 - Stimulus: O=0xFFFF, I2=0x0003, I3=0x0000.
 - Response: I1_out=0xFFAB (-85), sat=0.
REQ-037 Divide-by-zero and overflow:
 - O=0x0180, I2=0x0100, I3=0x0100 -> I1_out=0x7FFF, div0=1, sat=1, same latency.
 - O=0x7FFF, I2=0x0001, I3=0x0000 -> I1_out=0x7FFF, sat=1, div0=0.
REQ-038 Backpressure:
 - Stimulus: out_ready=0 for 10 cycles after out_valid rises.
 - Response: outputs held and in_ready=0 throughout; out_ready=1 -> out_valid=0 next cycle, in_ready=1.
REQ-039 Reset mid-DIV:
 - Stimulus: rst=1 at the 10th DIV cycle.
 - Response: no out_valid pulse, all outputs 0, in_ready=1 next cycle; the subsequent nominal vector still yields 0x0080.

Source files
------------

// File: rtl/subsystem_eq1_inv.sv
// Inverse of O = I3*I3*(1-I1) + I2*I1: recovers I1 = (O - t0)/(I2 - t0)
// with a fixed-latency restoring divider, saturation and divide-by-zero flag.
`ifndef FXP_N
`define FXP_N 16
`endif
`ifndef FXP_FRAC
`define FXP_FRAC 8
`endif

module subsystem_eq1_inv #(
  parameter int N    = `FXP_N,
  parameter int FRAC = `FXP_FRAC
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] O_in,
  input  logic [N-1:0] I2_in,
  input  logic [N-1:0] I3_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] I1_out,
  output logic         sat,
  output logic         div0
);

  localparam int W  = N + 1 + FRAC;
  localparam int CW = $clog2(W);

  localparam logic [W-1:0] POS_LIM = W'((1 << (N-1)) - 1);
  localparam logic [W-1:0] NEG_LIM = W'(1 << (N-1));
  localparam logic [N-1:0] MAX_V   = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MIN_V   = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, PREP, DIV, POST, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  o_q, o_d, i2_q, i2_d, i3_q, i3_d;
  logic [W-1:0]  dvd_q, dvd_d;
  logic [N:0]    rem_q, rem_d;
  logic [N:0]    den_mag_q, den_mag_d;
  logic          neg_q, neg_d;
  logic          num_neg_q, num_neg_d;
  logic          dz_q, dz_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  i1_q, i1_d;
  logic          sat_q, sat_d;
  logic          div0_q, div0_d;

  logic signed [2*N-1:0] sq;
  logic signed [N-1:0]   t0;
  logic [N:0]            num, den, num_mag, den_mag;
  logic [N+1:0]          rem_sh;
  logic                  q_bit;

  // Operand preparation, evaluated from the registered operands during PREP
  always_comb begin
    sq      = (2*N)'($signed(i3_q)) * (2*N)'($signed(i3_q));
    t0      = N'(sq >>> FRAC);
    num     = {o_q[N-1], o_q} - {t0[N-1], t0};
    den     = {i2_q[N-1], i2_q} - {t0[N-1], t0};
    num_mag = num[N] ? -num : num;
    den_mag = den[N] ? -den : den;
  end

  always_comb begin
    rem_sh = {rem_q, dvd_q[W-1]};
    q_bit  = (rem_sh >= {1'b0, den_mag_q});
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    o_d         = o_q;
    i2_d        = i2_q;
    i3_d        = i3_q;
    dvd_d       = dvd_q;
    rem_d       = rem_q;
    den_mag_d   = den_mag_q;
    neg_d       = neg_q;
    num_neg_d   = num_neg_q;
    dz_d        = dz_q;
    out_valid_d = out_valid_q;
    i1_d        = i1_q;
    sat_d       = sat_q;
    div0_d      = div0_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          o_d     = O_in;
          i2_d    = I2_in;
          i3_d    = I3_in;
          state_d = PREP;
        end
      end
      PREP: begin
        dvd_d     = {num_mag, {FRAC{1'b0}}};
        rem_d     = '0;
        den_mag_d = den_mag;
        neg_d     = num[N] ^ den[N];
        num_neg_d = num[N];
        dz_d      = (den == '0);
        cnt_d     = '0;
        state_d   = DIV;
      end
      DIV: begin
        // dividend shifts out the top while quotient bits shift in at the bottom
        rem_d = q_bit ? (N+1)'(rem_sh - {1'b0, den_mag_q}) : (N+1)'(rem_sh);
        dvd_d = {dvd_q[W-2:0], q_bit};
        if (cnt_q == CW'(W-1)) begin
          cnt_d   = '0;
          state_d = POST;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      POST: begin
        div0_d = dz_q;
        if (dz_q) begin
          i1_d  = num_neg_q ? MIN_V : MAX_V;
          sat_d = 1'b1;
        end else if (neg_q) begin
          sat_d = (dvd_q > NEG_LIM);
          i1_d  = sat_d ? MIN_V : -dvd_q[N-1:0];
        end else begin
          sat_d = (dvd_q > POS_LIM);
          i1_d  = sat_d ? MAX_V : dvd_q[N-1:0];
        end
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      o_q         <= '0;
      i2_q        <= '0;
      i3_q        <= '0;
      dvd_q       <= '0;
      rem_q       <= '0;
      den_mag_q   <= '0;
      neg_q       <= 1'b0;
      num_neg_q   <= 1'b0;
      dz_q        <= 1'b0;
      out_valid_q <= 1'b0;
      i1_q        <= '0;
      sat_q       <= 1'b0;
      div0_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      o_q         <= o_d;
      i2_q        <= i2_d;
      i3_q        <= i3_d;
      dvd_q       <= dvd_d;
      rem_q       <= rem_d;
      den_mag_q   <= den_mag_d;
      neg_q       <= neg_d;
      num_neg_q   <= num_neg_d;
      dz_q        <= dz_d;
      out_valid_q <= out_valid_d;
      i1_q        <= i1_d;
      sat_q       <= sat_d;
      div0_q      <= div0_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign I1_out    = i1_q;
  assign sat       = sat_q;
  assign div0      = div0_q;

endmodule
